axi_lite_reg_bank: RTL and testbench

// Parametrised AXI4-Lite slave register bank: NUM_REGS registers of DATA_W bits,

---
 rtl/axi_lite_reg_bank.sv | 197 +++++++++++++++++++
 tb/tb_axi_lite_reg_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_W registers with byte strobes,
// read-only slots backed by reg_in, SLVERR on out-of-range or read-only writes.
module axi_lite_reg_bank #(
    parameter int                  ADDR_W   = 12,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ADDR_W-1:0]            awAddr,
    input  logic [2:0]                   awProt,
    input  logic                         awValid,
    output logic                         awReady,
    input  logic [DATA_W-1:0]            wData,
    input  logic [DATA_W/8-1:0]          wStrb,
    input  logic                         wValid,
    output logic                         wReady,
    output logic [1:0]                   bResp,
    output logic                         bValid,
    input  logic                         bReady,
    input  logic [ADDR_W-1:0]            arAddr,
    input  logic [2:0]                   arProt,
    input  logic                         arValid,
    output logic                         arReady,
    output logic [DATA_W-1:0]            rData,
    output logic [1:0]                   rResp,
    output logic                         rValid,
    input  logic                         rReady,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < (IDX_W+1)'(NUM_REGS));
    endfunction

    function automatic logic idx_is_ro(input logic [IDX_W-1:0] idx);
        logic ro;
        ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) ro = RO_MASK[i];
        end
        return ro;
    endfunction

    // Protection bits and sub-word offset bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{awProt, arProt, awAddr[OFF_W-1:0], arAddr[OFF_W-1:0]};

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             wr_pulse_q, wr_pulse_d;
    logic                            aw_ready_q, aw_ready_d;
    logic                            w_ready_q, w_ready_d;
    logic                            aw_held_q, aw_held_d;
    logic                            w_held_q, w_held_d;
    logic [IDX_W-1:0]                aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]               w_data_q, w_data_d;
    logic [STRB_W-1:0]               w_strb_q, w_strb_d;
    logic                            b_valid_q, b_valid_d;
    logic [1:0]                      b_resp_q, b_resp_d;
    logic                            ar_ready_q, ar_ready_d;
    logic                            r_valid_q, r_valid_d;
    logic [DATA_W-1:0]               r_data_q, r_data_d;
    logic [1:0]                      r_resp_q, r_resp_d;

    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_ok;
    logic [IDX_W-1:0] ar_idx;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]       rd_resp;

    // Every channel transfers on the edge where its valid and ready are both high.
    assign aw_hs  = awValid && aw_ready_q;
    assign w_hs   = wValid && w_ready_q;
    assign b_hs   = b_valid_q && bReady;
    assign ar_hs  = arValid && ar_ready_q;
    assign r_hs   = r_valid_q && rReady;
    assign commit = aw_held_q && w_held_q && !b_valid_q;
    assign wr_ok  = idx_in_range(aw_idx_q) && !idx_is_ro(aw_idx_q);
    assign ar_idx = arAddr[ADDR_W-1:OFF_W];

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awAddr[ADDR_W-1:OFF_W];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = wData;
            w_strb_d = wStrb;
        end
        if (commit) begin
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && aw_idx_q == IDX_W'(i)) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_strb_q[k]) regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                    end
                    wr_pulse_d[i] = |w_strb_q;
                end
            end
        end else if (b_hs) begin
            b_valid_d = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        aw_ready_d = !aw_held_d && !b_valid_d;
        w_ready_d  = !w_held_d && !b_valid_d;
    end

    // Read sources regs_q, so a same-edge write commit is not visible to it.
    always_comb begin
        rd_data = '0;
        rd_resp = idx_in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_data = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_data;
            r_resp_d  = rd_resp;
        end else if (r_hs) begin
            r_valid_d = 1'b0;
        end
        ar_ready_d = !r_valid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign awReady  = aw_ready_q;
    assign wReady   = w_ready_q;
    assign bValid   = b_valid_q;
    assign bResp    = b_resp_q;
    assign arReady  = ar_ready_q;
    assign rValid   = r_valid_q;
    assign rData    = r_data_q;
    assign rResp    = r_resp_q;
    assign reg_out  = regs_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank (32-bit data, 16 regs, reg 5 read-only).
module tb_axi_lite_reg_bank;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam logic [NREG-1:0] RO = 16'h0020;

    logic                   aclk, aresetn;
    logic [ADDR_W-1:0]      awAddr, arAddr;
    logic [2:0]             awProt, arProt;
    logic                   awValid, awReady, wValid, wReady, bValid, bReady;
    logic                   arValid, arReady, rValid, rReady;
    logic [DATA_W-1:0]      wData, rData;
    logic [3:0]             wStrb;
    logic [1:0]             bResp, rResp;
    logic [NREG*DATA_W-1:0] reg_out, reg_in;
    logic [NREG-1:0]        wr_pulse;

    logic [NREG*DATA_W-1:0] exp_regs;
    int n_vec = 0;
    int n_err = 0;

    axi_lite_reg_bank #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NREG), .RO_MASK(RO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awAddr(awAddr), .awProt(awProt), .awValid(awValid), .awReady(awReady),
        .wData(wData), .wStrb(wStrb), .wValid(wValid), .wReady(wReady),
        .bResp(bResp), .bValid(bValid), .bReady(bReady),
        .arAddr(arAddr), .arProt(arProt), .arValid(arValid), .arReady(arReady),
        .rData(rData), .rResp(rResp), .rValid(rValid), .rReady(rReady),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw();
        int n = 0;
        awValid = 1'b1;
        while (!awReady && n < 50) begin step(); n++; end
        chk("aw_ready_wait", awReady, 1);
        step();
        awValid = 1'b0;
    endtask

    task automatic send_w();
        int n = 0;
        wValid = 1'b1;
        while (!wReady && n < 50) begin step(); n++; end
        chk("w_ready_wait", wReady, 1);
        step();
        wValid = 1'b0;
    endtask

    // order: 0 AW then W, 1 W then AW, 2 same cycle
    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input bit accept, input logic [1:0] exp_resp,
                            input logic [15:0] exp_pulse);
        int n = 0;
        awAddr = addr;
        wData  = data;
        wStrb  = strb;
        if (order == 0) begin
            send_aw();
            chk("aw_ready_drop", awReady, 0);
            send_w();
        end else if (order == 1) begin
            send_w();
            chk("w_ready_drop", wReady, 0);
            send_aw();
        end else begin
            awValid = 1'b1;
            wValid  = 1'b1;
            while (!(awReady && wReady) && n < 50) begin step(); n++; end
            chk("aww_ready_wait", awReady && wReady, 1);
            step();
            awValid = 1'b0;
            wValid  = 1'b0;
        end
        chk("b_early", bValid, 0);
        step();
        chk("b_valid", bValid, 1);
        chk("b_resp", bResp, exp_resp);
        chk("wr_pulse", wr_pulse, exp_pulse);
        chk("reg_out", reg_out, exp_regs);
        if (accept) begin
            bReady = 1'b1;
            step();
            bReady = 1'b0;
            chk("b_clear", bValid, 0);
            chk("pulse_width", wr_pulse, 0);
            chk("aw_ready_back", awReady, 1);
            chk("w_ready_back", wReady, 1);
        end
    endtask

    task automatic do_read(input logic [11:0] addr, input int hold,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n = 0;
        arAddr  = addr;
        arValid = 1'b1;
        while (!arReady && n < 50) begin step(); n++; end
        chk("ar_ready_wait", arReady, 1);
        step();
        arValid = 1'b0;
        chk("r_latency", rValid, 1);
        chk("r_data", rData, exp_data);
        chk("r_resp", rResp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("r_hold_valid", rValid, 1);
            chk("r_hold_data", rData, exp_data);
            chk("ar_ready_held", arReady, 0);
        end
        rReady = 1'b1;
        step();
        rReady = 1'b0;
        chk("r_clear", rValid, 0);
        chk("ar_ready_back", arReady, 1);
    endtask

    initial begin
        aresetn = 1'b0;
        awAddr = '0; awProt = 3'b000; awValid = 1'b0;
        wData = '0; wStrb = '0; wValid = 1'b0; bReady = 1'b0;
        arAddr = '0; arProt = 3'b000; arValid = 1'b0; rReady = 1'b0;
        reg_in = '0;
        reg_in[5*32 +: 32] = 32'hCAFE_0005;
        exp_regs = '0;

        repeat (2) step();
        chk("rst_aw_ready", awReady, 0);
        chk("rst_w_ready", wReady, 0);
        chk("rst_ar_ready", arReady, 0);
        chk("rst_reg_out", reg_out, 0);
        aresetn = 1'b1;
        step();
        chk("rel_aw_ready", awReady, 1);
        chk("rel_w_ready", wReady, 1);
        chk("rel_ar_ready", arReady, 1);
        chk("rel_b_valid", bValid, 0);
        chk("rel_r_valid", rValid, 0);
        chk("rel_reg_out", reg_out, 0);

        exp_regs[2*32 +: 32] = 32'hDEAD_BEEF;
        do_write(12'h008, 32'hDEAD_BEEF, 4'hF, 0, 1, 2'b00, 16'h0004);
        exp_regs[2*32 +: 32] = 32'hDE22_BE44;
        do_write(12'h008, 32'h1122_3344, 4'b0101, 1, 1, 2'b00, 16'h0004);
        do_write(12'h040, 32'h9999_9999, 4'hF, 0, 1, 2'b10, 16'h0000);
        do_write(12'h014, 32'h8888_8888, 4'hF, 2, 1, 2'b10, 16'h0000);
        do_write(12'h00C, 32'hFFFF_FFFF, 4'h0, 2, 1, 2'b00, 16'h0000);
        exp_regs[3*32 +: 32] = 32'hA5A5_A5A5;
        do_write(12'h00E, 32'hA5A5_A5A5, 4'hF, 1, 1, 2'b00, 16'h0008);

        do_read(12'h008, 5, 32'hDE22_BE44, 2'b00);
        do_read(12'h040, 0, 32'h0000_0000, 2'b10);
        do_read(12'h014, 1, 32'hCAFE_0005, 2'b00);
        do_read(12'h00D, 0, 32'hA5A5_A5A5, 2'b00);

        // Read completes while a write response sits unaccepted.
        exp_regs[1*32 +: 32] = 32'h0BAD_F00D;
        do_write(12'h004, 32'h0BAD_F00D, 4'hF, 2, 0, 2'b00, 16'h0002);
        do_read(12'h008, 2, 32'hDE22_BE44, 2'b00);
        chk("b_still_pending", bValid, 1);
        bReady = 1'b1;
        step();
        bReady = 1'b0;
        chk("b_late_clear", bValid, 0);

        // Write commit and read handshake on the same edge to reg 2.
        awAddr = 12'h008; wData = 32'h5566_7788; wStrb = 4'hF;
        awValid = 1'b1; wValid = 1'b1;
        step();
        awValid = 1'b0; wValid = 1'b0;
        arAddr = 12'h008; arValid = 1'b1;
        chk("coll_ar_ready", arReady, 1);
        step();
        arValid = 1'b0;
        exp_regs[2*32 +: 32] = 32'h5566_7788;
        chk("coll_r_valid", rValid, 1);
        chk("coll_r_data", rData, 32'hDE22_BE44);
        chk("coll_b_valid", bValid, 1);
        chk("coll_reg_out", reg_out, exp_regs);
        chk("coll_pulse", wr_pulse, 16'h0004);
        rReady = 1'b1; bReady = 1'b1;
        step();
        rReady = 1'b0; bReady = 1'b0;
        chk("coll_b_clear", bValid, 0);
        chk("coll_r_clear", rValid, 0);

        // Reset while a write response is pending.
        exp_regs[6*32 +: 32] = 32'h7777_7777;
        do_write(12'h018, 32'h7777_7777, 4'hF, 0, 0, 2'b00, 16'h0040);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_b_valid", bValid, 0);
        chk("mid_rst_aw_ready", awReady, 0);
        chk("mid_rst_reg_out", reg_out, 0);
        chk("mid_rst_pulse", wr_pulse, 0);
        exp_regs = '0;
        step();
        step();
        aresetn = 1'b1;
        step();
        chk("post_rst_aw_ready", awReady, 1);
        exp_regs[4*32 +: 32] = 32'h1234_5678;
        do_write(12'h010, 32'h1234_5678, 4'hF, 2, 1, 2'b00, 16'h0010);
        do_read(12'h010, 0, 32'h1234_5678, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
